// File: rtl/wallace_tree_signed_mult.sv
// Signed 8x8 two's-complement multiplier with a registered 16-bit product.
// Baugh-Wooley partial products are reduced by a Wallace tree of full and half
// adders until two rows remain. A final carry-propagate add forms the product,
// which is captured in an output register.
//
// Ports:
//   clk       system clock, rising-edge active
//   rst       asynchronous, active-high reset
//   in_valid  operands a/b valid this cycle; launches a multiply
//   a, b      signed 8-bit operands
//   out_valid one-cycle pulse when product holds a new result
//   product   registered signed 16-bit product a*b
module wallace_tree_signed_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  output logic [15:0] product
);

  // Builds the Baugh-Wooley bit heap and reduces it Wallace-style.
  // Returns {row1, row0}; their 16-bit sum is the product.
  function automatic logic [31:0] wallace_reduce(input logic [7:0] x, input logic [7:0] y);
    logic heap  [16][16];
    logic nheap [16][16];
    int   cnt   [16];
    int   ncnt  [16];
    int   maxh;
    int   idx;
    logic s;
    logic co;
    logic [15:0] row0;
    logic [15:0] row1;

    for (int c = 0; c < 16; c++) begin
      cnt[c]  = 0;
      ncnt[c] = 0;
      for (int k = 0; k < 16; k++) begin
        heap[c][k]  = 1'b0;
        nheap[c][k] = 1'b0;
      end
    end

    // Partial products: terms with exactly one sign bit are inverted.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        logic p;
        p = x[j] & y[i];
        if ((i == 7) != (j == 7)) p = ~p;
        heap[i+j][cnt[i+j]] = p;
        cnt[i+j]++;
      end
    end

    // Baugh-Wooley correction constant 2^8 + 2^15.
    heap[8][cnt[8]] = 1'b1;
    cnt[8]++;
    heap[15][cnt[15]] = 1'b1;
    cnt[15]++;

    // Each stage compresses every column in groups of 3 (FA) then 2 (HA).
    // Carries out of column 15 fall off the top.
    for (int st = 0; st < 8; st++) begin
      maxh = 0;
      for (int c = 0; c < 16; c++) begin
        if (cnt[c] > maxh) maxh = cnt[c];
      end
      if (maxh > 2) begin
        for (int c = 0; c < 16; c++) begin
          ncnt[c] = 0;
        end
        for (int c = 0; c < 16; c++) begin
          idx = 0;
          while (cnt[c] - idx >= 3) begin
            s  = heap[c][idx] ^ heap[c][idx+1] ^ heap[c][idx+2];
            co = (heap[c][idx] & heap[c][idx+1]) | (heap[c][idx+2] &
                 (heap[c][idx] ^ heap[c][idx+1]));
            nheap[c][ncnt[c]] = s;
            ncnt[c]++;
            if (c < 15) begin
              nheap[c+1][ncnt[c+1]] = co;
              ncnt[c+1]++;
            end
            idx += 3;
          end
          if (cnt[c] - idx == 2) begin
            s  = heap[c][idx] ^ heap[c][idx+1];
            co = heap[c][idx] & heap[c][idx+1];
            nheap[c][ncnt[c]] = s;
            ncnt[c]++;
            if (c < 15) begin
              nheap[c+1][ncnt[c+1]] = co;
              ncnt[c+1]++;
            end
          end else if (cnt[c] - idx == 1) begin
            nheap[c][ncnt[c]] = heap[c][idx];
            ncnt[c]++;
          end
        end
        for (int c = 0; c < 16; c++) begin
          cnt[c] = ncnt[c];
          for (int k = 0; k < 16; k++) begin
            heap[c][k] = nheap[c][k];
          end
        end
      end
    end

    for (int c = 0; c < 16; c++) begin
      row0[c] = (cnt[c] > 0) ? heap[c][0] : 1'b0;
      row1[c] = (cnt[c] > 1) ? heap[c][1] : 1'b0;
    end
    return {row1, row0};
  endfunction

  logic [31:0] rows;
  logic [15:0] sum_d;

  always_comb begin
    rows  = wallace_reduce(a, b);
    sum_d = rows[31:16] + rows[15:0];
  end

  // Product only loads on in_valid, so a/b are don't-care otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product   <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        product <= sum_d;
      end
    end
  end

endmodule

// File: tb/tb_wallace_tree_signed_mult.sv
module tb_wallace_tree_signed_mult;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic [15:0] product;

  int checks;
  int errors;

  wallace_tree_signed_mult dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operand pair at the falling edge, check the result after the next rising edge.
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic [15:0] exp);
    @(negedge clk);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    @(posedge clk);
    #1;
    check({tag, " product"}, product, exp);
    check({tag, " out_valid"}, {15'd0, out_valid}, 16'h0001);
  endtask

  task automatic idle_cycle(input string tag, input logic [15:0] exp_prod,
                            input logic [7:0] ta, input logic [7:0] tb);
    @(negedge clk);
    in_valid = 1'b0;
    a        = ta;
    b        = tb;
    @(posedge clk);
    #1;
    check({tag, " product"}, product, exp_prod);
    check({tag, " out_valid"}, {15'd0, out_valid}, 16'h0000);
  endtask

  initial begin
    logic [7:0]  sa;
    logic [7:0]  sb;
    logic [15:0] se;
    int          sweep_err;

    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset product", product, 16'h0000);
    check("reset out_valid", {15'd0, out_valid}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Make product nonzero, then assert reset mid-cycle.
    do_op("pre-reset", 8'h07, 8'h09, 16'h003F);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async reset product", product, 16'h0000);
    check("async reset out_valid", {15'd0, out_valid}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    idle_cycle("post-reset idle1", 16'h0000, 8'h12, 8'h34);
    idle_cycle("post-reset idle2", 16'h0000, 8'h56, 8'h78);

    // Operation launched while reset asserts is lost.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'h11;
    b        = 8'h11;
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("lost op product", product, 16'h0000);
    check("lost op out_valid", {15'd0, out_valid}, 16'h0000);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    idle_cycle("lost op after release", 16'h0000, 8'h11, 8'h11);

    do_op("0*0", 8'h00, 8'h00, 16'h0000);
    do_op("-1*1", 8'hFF, 8'h01, 16'hFFFF);
    do_op("3*3", 8'h03, 8'h03, 16'h0009);
    do_op("AA*55", 8'hAA, 8'h55, 16'hE372);
    do_op("-1*3", 8'hFF, 8'h03, 16'hFFFD);
    do_op("-1*-1", 8'hFF, 8'hFF, 16'h0001);
    do_op("-128*-128", 8'h80, 8'h80, 16'h4000);
    do_op("-128*127", 8'h80, 8'h7F, 16'hC080);
    do_op("127*127", 8'h7F, 8'h7F, 16'h3F01);

    do_op("5*-3", 8'h05, 8'hFD, 16'hFFF1);
    idle_cycle("hold1", 16'hFFF1, 8'h22, 8'h33);
    idle_cycle("hold2", 16'hFFF1, 8'hC4, 8'h7E);

    do_op("b2b 1", 8'h10, 8'h10, 16'h0100);
    do_op("b2b 2", 8'hF0, 8'h10, 16'hFF00);
    do_op("b2b 3", 8'h81, 8'h02, 16'hFF02);
    idle_cycle("b2b end", 16'hFF02, 8'h00, 8'h00);

    // Exhaustive streamed sweep against the language's signed multiply.
    sweep_err = 0;
    for (int i = 0; i < 65536; i++) begin
      sa = i[15:8];
      sb = i[7:0];
      se = 16'($signed(sa) * $signed(sb));
      @(negedge clk);
      in_valid = 1'b1;
      a        = sa;
      b        = sb;
      @(posedge clk);
      #1;
      if (product !== se || out_valid !== 1'b1) begin
        sweep_err++;
        if (sweep_err <= 10) begin
          $display("FAIL sweep a=%h b=%h: got %h valid %b expected %h valid 1",
                   sa, sb, product, out_valid, se);
        end
      end
    end
    checks++;
    if (sweep_err != 0) errors++;
    @(negedge clk);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wallace_tree_signed_mult.md
Name: wallace_tree_signed_mult

Overview:
Signed 8x8 two's-complement multiplier with a 16-bit product.
- Partial products use Baugh-Wooley sign handling, reduced by a Wallace tree of 3:2/2:2 compressors, then a final carry-propagate adder.
- The result is captured in an output register.
- Used as the signed multiply datapath element; single clock domain.

Parameters:
None. Operand width is fixed at 8 bits and product width at 16 bits; the tree structure is specific to 8x8.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands a/b valid this cycle; launches a multiply
a  input  8  multiplicand, signed two's complement
b  input  8  multiplier, signed two's complement
out_valid  output  1  product holds a new result (one-cycle pulse per accepted operand pair)
product  output  16  signed two's complement product a*b, registered

Behaviour:
- Reset (rst=1, asynchronous, independent of clk): product=16'h0000, out_valid=0 immediately. Both stay at zero until the first accepted operation after rst deasserts.
- Arithmetic: product = sign-extended(a) * sign-extended(b), exact, 16-bit two's complement.
- No overflow is possible. Extremes:
  - -128*-128 = +16384 = 16'h4000
  - -128*127 = 16'hC080
- Partial products, Baugh-Wooley form:
  - pp[i][j] = a[j]&b[i] for i,j<7.
  - Row/column terms involving exactly one sign bit (a[7] or b[7]) are inverted.
  - a[7]&b[7] is not inverted.
  - Correction constant 1 is added at bit 8 and bit 15.
  - Carries beyond bit 15 are discarded.
- Reduction: Wallace tree. Each stage compresses every column with full adders (3 bits) and half adders (2 bits) until at most two rows remain. A 16-bit ripple or any CPA then forms the sum.
- The reduction tree is purely combinational from a/b.
- Latency: exactly 1 clock.
  - On a rising clk with in_valid=1: product <= a*b and out_valid <= 1.
  - On a rising clk with in_valid=0: product holds its previous value and out_valid <= 0.
- Throughput: one multiply per cycle. Back-to-back in_valid is fully pipelined; each result appears one cycle after its operands.
- Reset mid-operation: an operation launched in the cycle where rst asserts is lost. No output appears for it after reset release.
- X/Z on a or b while in_valid=0 must not affect product.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle with product nonzero -> product=16'h0000 and out_valid=0 at once, before any clk edge; both remain 0 after release until in_valid.
2. Basic signed cases, one per cycle with in_valid=1. Each result appears on the next edge with out_valid=1:
   - a=8'h00, b=8'h00 -> 16'h0000
   - a=8'hFF, b=8'h01 -> 16'hFFFF
   - a=8'h03, b=8'h03 -> 16'h0009
3. Mixed and negative operands:
   - a=8'hAA, b=8'h55 -> 16'hE372
   - a=8'hFF, b=8'h03 -> 16'hFFFD
   - a=8'hFF, b=8'hFF -> 16'h0001
4. Extremes:
   - a=8'h80, b=8'h80 -> 16'h4000
   - a=8'h80, b=8'h7F -> 16'hC080
   - a=8'h7F, b=8'h7F -> 16'h3F01
5. Hold and valid: issue a=8'h05, b=8'hFD (-> 16'hFFF1), then drop in_valid and change a/b -> product stays 16'hFFF1 and out_valid=0 on following edges. Back-to-back in_valid for 3 cycles -> 3 consecutive out_valid pulses with the matching products.
6. Exhaustive sweep of all 65536 (a,b) pairs streamed back-to-back -> every product equals $signed(a)*$signed(b) one cycle later, with zero mismatches.
